// File: rtl/yuv_to_rgb_pkg.sv
// Shared widths and channel indices for the YUV to RGB colour-space converter.
package yuv_to_rgb_pkg;

    localparam int COEF_W    = 8;
    localparam int COEF_FRAC = 6;
    localparam int PIX_W     = 8;
    localparam int OUT_W     = 7;
    localparam int SUM_W     = 18;
    localparam int NUM_CH    = 3;

    // Round-half-up bias and shift applied to the Q1.6 weighted sum.
    localparam int RND_BIAS  = 1 << COEF_FRAC;
    localparam int RND_SHIFT = COEF_FRAC + 1;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } channel_e;

endpackage

// File: rtl/yuv_mac_channel.sv
// One colour channel: three registered Q1.6 products, then sum, round and
// clamp into the channel output register.
module yuv_mac_channel
    import yuv_to_rgb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en_i,
    input  logic               out_en_i,
    input  logic [COEF_W-1:0]  coef_y_i,
    input  logic [COEF_W-1:0]  coef_u_i,
    input  logic [COEF_W-1:0]  coef_v_i,
    input  logic [PIX_W-1:0]   y_i,
    input  logic [PIX_W-1:0]   u_i,
    input  logic [PIX_W-1:0]   v_i,
    output logic [OUT_W-1:0]   chan_o
);

    logic signed [SUM_W-1:0] y_ext, u_ext, v_ext;
    logic signed [SUM_W-1:0] cy_ext, cu_ext, cv_ext;
    logic signed [SUM_W-1:0] prod_y_d, prod_u_d, prod_v_d;
    logic signed [SUM_W-1:0] prod_y_q, prod_u_q, prod_v_q;
    logic signed [SUM_W-1:0] sum, rounded, shifted;
    logic [OUT_W-1:0]        chan_d, chan_q;

    // Y is unsigned luma; U, V and every coefficient are two's complement.
    assign y_ext  = SUM_W'($signed({1'b0, y_i}));
    assign u_ext  = SUM_W'($signed(u_i));
    assign v_ext  = SUM_W'($signed(v_i));
    assign cy_ext = SUM_W'($signed(coef_y_i));
    assign cu_ext = SUM_W'($signed(coef_u_i));
    assign cv_ext = SUM_W'($signed(coef_v_i));

    assign prod_y_d = cy_ext * y_ext;
    assign prod_u_d = cu_ext * u_ext;
    assign prod_v_d = cv_ext * v_ext;

    assign sum     = prod_y_q + prod_u_q + prod_v_q;
    assign rounded = sum + SUM_W'(RND_BIAS);
    assign shifted = rounded >>> RND_SHIFT;

    // Negative results saturate to zero, anything above the output range to all ones.
    always_comb begin
        chan_d = shifted[OUT_W-1:0];
        if (shifted[SUM_W-1]) begin
            chan_d = '0;
        end else if (|shifted[SUM_W-2:OUT_W]) begin
            chan_d = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_y_q <= '0;
            prod_u_q <= '0;
            prod_v_q <= '0;
            chan_q   <= '0;
        end else begin
            if (load_en_i) begin
                prod_y_q <= prod_y_d;
                prod_u_q <= prod_u_d;
                prod_v_q <= prod_v_d;
            end
            if (out_en_i) begin
                chan_q <= chan_d;
            end
        end
    end

    assign chan_o = chan_q;

endmodule

// File: rtl/yuv_to_rgb.sv
// Joins Y/U/V pixel streams, applies a loadable 3x3 Q1.6 matrix and emits packed
// 7-bit RGB through a two-stage pipeline with valid/ready flow control.
module yuv_to_rgb
    import yuv_to_rgb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  y_valid,
    output logic                  y_ready,
    input  logic [PIX_W-1:0]      y_data,
    input  logic                  u_valid,
    output logic                  u_ready,
    input  logic [PIX_W-1:0]      u_data,
    input  logic                  v_valid,
    output logic                  v_ready,
    input  logic [PIX_W-1:0]      v_data,
    input  logic                  coeffs_valid,
    output logic                  coeffs_ready,
    input  logic [9*COEF_W-1:0]   coeffs_data,
    output logic                  rgb_valid,
    input  logic                  rgb_ready,
    output logic [3*OUT_W-1:0]    rgb_data
);

    logic [9*COEF_W-1:0] coef_q, coef_d;
    logic                loaded_q, loaded_d;
    logic                s1_valid_q, s1_valid_d;
    logic                rgb_valid_q, rgb_valid_d;
    logic                advance, coef_xfer, fire;
    logic [OUT_W-1:0]    chan_out [NUM_CH];

    assign advance      = !rgb_valid_q || rgb_ready;
    // Coefficients only change while nothing is in flight, so every pixel sees one matrix.
    assign coeffs_ready = !s1_valid_q && !rgb_valid_q;
    assign coef_xfer    = coeffs_valid && coeffs_ready;
    assign fire         = loaded_q && y_valid && u_valid && v_valid && advance && !coef_xfer;

    assign y_ready = fire;
    assign u_ready = fire;
    assign v_ready = fire;

    always_comb begin
        coef_d      = coef_q;
        loaded_d    = loaded_q;
        s1_valid_d  = s1_valid_q;
        rgb_valid_d = rgb_valid_q;
        if (coef_xfer) begin
            coef_d   = coeffs_data;
            loaded_d = 1'b1;
        end
        if (advance) begin
            s1_valid_d  = fire;
            rgb_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_q      <= '0;
            loaded_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            rgb_valid_q <= 1'b0;
        end else begin
            coef_q      <= coef_d;
            loaded_q    <= loaded_d;
            s1_valid_q  <= s1_valid_d;
            rgb_valid_q <= rgb_valid_d;
        end
    end

    // Channel gi uses coefficients 3*gi .. 3*gi+2 (weights for Y, U, V).
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam int BASE = gi * 3 * COEF_W;
        yuv_mac_channel u_ch (
            .clk       (clk),
            .rst       (rst),
            .load_en_i (fire),
            .out_en_i  (advance && s1_valid_q),
            .coef_y_i  (coef_q[BASE +: COEF_W]),
            .coef_u_i  (coef_q[BASE + COEF_W +: COEF_W]),
            .coef_v_i  (coef_q[BASE + 2*COEF_W +: COEF_W]),
            .y_i       (y_data),
            .u_i       (u_data),
            .v_i       (v_data),
            .chan_o    (chan_out[gi])
        );
    end

    assign rgb_valid = rgb_valid_q;
    assign rgb_data  = {chan_out[CH_R], chan_out[CH_G], chan_out[CH_B]};

endmodule

// File: tb/tb_yuv_to_rgb.sv
// Scoreboard bench for yuv_to_rgb: directed pixels with hand-computed RGB results.
module tb_yuv_to_rgb;

    logic        clk = 1'b0;
    logic        rst;
    logic        y_valid, u_valid, v_valid;
    logic        y_ready, u_ready, v_ready;
    logic [7:0]  y_data, u_data, v_data;
    logic        coeffs_valid, coeffs_ready;
    logic [71:0] coeffs_data;
    logic        rgb_valid, rgb_ready;
    logic [20:0] rgb_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fire_count = 0;
    bit lat_check = 1'b1;
    logic [20:0] exp_q[$];
    int          fire_q[$];
    logic [20:0] mon_exp;
    int          mon_fire;
    logic [20:0] bp_held;
    bit          bp_have;
    int          base;

    // Coefficient sets, bytes k0..k8 (R row, G row, B row; each Y,U,V).
    logic [71:0] coef_a, coef_b, coef_c;

    yuv_to_rgb dut (
        .clk          (clk),
        .rst          (rst),
        .y_valid      (y_valid),
        .y_ready      (y_ready),
        .y_data       (y_data),
        .u_valid      (u_valid),
        .u_ready      (u_ready),
        .u_data       (u_data),
        .v_valid      (v_valid),
        .v_ready      (v_ready),
        .v_data       (v_data),
        .coeffs_valid (coeffs_valid),
        .coeffs_ready (coeffs_ready),
        .coeffs_data  (coeffs_data),
        .rgb_valid    (rgb_valid),
        .rgb_ready    (rgb_ready),
        .rgb_data     (rgb_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [71:0] pack9(input logic [7:0] k0, k1, k2, k3, k4, k5, k6, k7, k8);
        return {k8, k7, k6, k5, k4, k3, k2, k1, k0};
    endfunction

    function automatic logic [20:0] px(input logic [6:0] r, g, b);
        return {r, g, b};
    endfunction

    function automatic logic [20:0] gray(input logic [6:0] n);
        return {n, n, n};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted output is popped and compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && rgb_valid && rgb_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h required no output", rgb_data);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_fire = fire_q.pop_front();
                $display("OUT cyc=%0d rgb=%h expected=%h", cyc, rgb_data, mon_exp);
                chk("rgb_data", 32'(rgb_data), 32'(mon_exp));
                if (lat_check) chk("latency", 32'(cyc - mon_fire), 32'd2);
            end
        end
    end

    task automatic send_px(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                           input logic [20:0] exp);
        int w = 0;
        y_data = y; u_data = u; v_data = v;
        y_valid = 1'b1; u_valid = 1'b1; v_valid = 1'b1;
        @(negedge clk);
        while (!(y_ready && u_ready && v_ready)) begin
            w++;
            if (w > 100) break;
            @(negedge clk);
        end
        if (w > 100) begin
            chk("send_timeout", 32'(w), 32'd0);
        end else begin
            exp_q.push_back(exp);
            fire_q.push_back(cyc);
            fire_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        y_valid = 1'b0; u_valid = 1'b0; v_valid = 1'b0;
    endtask

    task automatic load_coeffs(input logic [71:0] c);
        int w = 0;
        coeffs_data  = c;
        coeffs_valid = 1'b1;
        @(negedge clk);
        while (!coeffs_ready) begin
            w++;
            if (w > 100) break;
            @(negedge clk);
        end
        if (w > 100) chk("coeff_timeout", 32'(w), 32'd0);
        @(posedge clk);
        #1;
        coeffs_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        coef_a = pack9(8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00);
        coef_b = pack9(8'h40, 8'h7F, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h40);
        coef_c = pack9(8'h20, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 8'h40, 8'h00, 8'hC0);
        rst = 1'b1;
        y_valid = 1'b0; u_valid = 1'b0; v_valid = 1'b0;
        y_data = '0; u_data = '0; v_data = '0;
        coeffs_valid = 1'b0; coeffs_data = '0;
        rgb_ready = 1'b1;

        // Reset state, during and just after reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rgb_valid", 32'(rgb_valid), 32'd0);
        chk("rst_rgb_data", 32'(rgb_data), 32'd0);
        chk("rst_y_ready", 32'(y_ready), 32'd0);
        chk("rst_coeffs_ready", 32'(coeffs_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_y_ready", 32'(y_ready), 32'd0);
        chk("post_rst_coeffs_ready", 32'(coeffs_ready), 32'd1);

        // Pixels offered before any coefficient load are refused
        @(posedge clk); #1;
        y_data = 8'd200; u_data = 8'd0; v_data = 8'd0;
        y_valid = 1'b1; u_valid = 1'b1; v_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("noload_ready", 32'({y_ready, u_ready, v_ready}), 32'd0);
        end
        @(posedge clk); #1;

        // Pass-through matrix, first pixel and a back-to-back stream with clamp at 255
        load_coeffs(coef_a);
        send_px(8'd200, 8'd0, 8'd0, gray(7'd100));
        send_px(8'd0,   8'd0, 8'd0, gray(7'd0));
        send_px(8'd1,   8'd0, 8'd0, gray(7'd1));
        send_px(8'd127, 8'd0, 8'd0, gray(7'd64));
        send_px(8'd255, 8'd0, 8'd0, gray(7'd127));
        idle();
        drain();

        // Backpressure: six pixels while the output is stalled for five cycles
        lat_check = 1'b0;
        rgb_ready = 1'b0;
        bp_have = 1'b0;
        base = fire_count;
        fork
            begin
                for (int i = 1; i <= 6; i++) send_px(8'(10 * i), 8'd0, 8'd0, gray(7'(5 * i)));
                idle();
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (rgb_valid) begin
                        if (!bp_have) begin
                            bp_held = rgb_data;
                            bp_have = 1'b1;
                        end else begin
                            chk("bp_hold_stable", 32'(rgb_data), 32'(bp_held));
                        end
                    end
                end
                chk("bp_accepted", 32'(fire_count - base), 32'd2);
                chk("bp_y_ready_low", 32'(y_ready), 32'd0);
                chk("bp_rgb_valid", 32'(rgb_valid), 32'd1);
                @(posedge clk); #1;
                rgb_ready = 1'b1;
            end
        join
        drain();
        lat_check = 1'b1;

        // Join: V missing for four cycles, then one joint transfer
        y_data = 8'd80; u_data = 8'd5; v_data = 8'd5;
        y_valid = 1'b1; u_valid = 1'b1; v_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("join_ready_low", 32'({y_ready, u_ready, v_ready}), 32'd0);
        end
        @(posedge clk); #1;
        base = fire_count;
        send_px(8'd80, 8'd5, 8'd5, gray(7'd40));
        idle();
        @(negedge clk);
        chk("join_single", 32'(fire_count - base), 32'd1);
        chk("join_ready_after", 32'({y_ready, u_ready, v_ready}), 32'd0);
        drain();

        // Coefficient transfer wins over a simultaneously offered pixel
        coeffs_data = coef_b; coeffs_valid = 1'b1;
        y_data = 8'd255; u_data = 8'd127; v_data = 8'd0;
        y_valid = 1'b1; u_valid = 1'b1; v_valid = 1'b1;
        @(negedge clk);
        chk("prio_coeffs_ready", 32'(coeffs_ready), 32'd1);
        chk("prio_y_ready", 32'(y_ready), 32'd0);
        @(posedge clk); #1;
        coeffs_valid = 1'b0;
        send_px(8'd255, 8'd127, 8'd0, px(7'd127, 7'd0, 7'd0));
        send_px(8'd0, 8'hF6, 8'd100, px(7'd0, 7'd10, 7'd50));
        idle();
        drain();

        // Reload attempted with two pixels in flight
        lat_check = 1'b0;
        coeffs_data = coef_a; coeffs_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        coeffs_valid = 1'b0;
        rgb_ready = 1'b0;
        send_px(8'd100, 8'd0, 8'd0, gray(7'd50));
        send_px(8'd150, 8'd0, 8'd0, gray(7'd75));
        idle();
        coeffs_data = coef_c; coeffs_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reload_blocked", 32'(coeffs_ready), 32'd0);
        end
        @(posedge clk); #1;
        rgb_ready = 1'b1;
        load_coeffs(coef_c);
        lat_check = 1'b1;
        send_px(8'd100, 8'd20, 8'd30, px(7'd25, 7'd60, 7'd35));
        send_px(8'd200, 8'd0,  8'd0,  px(7'd50, 7'd100, 7'd100));
        idle();
        drain();

        // Reset with two pixels in flight: outputs discarded
        lat_check = 1'b0;
        rgb_ready = 1'b0;
        send_px(8'd100, 8'd20, 8'd30, px(7'd25, 7'd60, 7'd35));
        send_px(8'd200, 8'd0,  8'd0,  px(7'd50, 7'd100, 7'd100));
        chk("pre_rst_valid", 32'(rgb_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(rgb_valid), 32'd0);
        chk("async_rst_data", 32'(rgb_data), 32'd0);
        chk("async_rst_coeffs_ready", 32'(coeffs_ready), 32'd1);
        exp_q.delete();
        fire_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        rgb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("after_rst_ready", 32'(y_ready), 32'd0);
            chk("after_rst_valid", 32'(rgb_valid), 32'd0);
        end
        @(posedge clk); #1;
        idle();

        // Recovery after new coefficients
        lat_check = 1'b1;
        load_coeffs(coef_a);
        send_px(8'd200, 8'd0, 8'd0, gray(7'd100));
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
